// File: rtl/reg_file.sv
// Architectural register file with ROB rename tags: value-or-tag operand reads, commit writes, and a mispredict flush that drops all tags.
// Optional macro REG_FILE_COMMIT_BYPASS_EN forwards a same-cycle commit onto the read ports.
module reg_file #(
  parameter int XLEN         = 32,
  parameter int REG_ID_WIDTH = 5,
  parameter int ROB_ID_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    reset_from_rob_bus,
  input  logic                    valid_from_issuer,
  input  logic [REG_ID_WIDTH-1:0] rd_from_issuer,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_issuer,
  input  logic [REG_ID_WIDTH-1:0] rs1_from_issuer,
  output logic [ROB_ID_WIDTH-1:0] qj_to_issuer,
  output logic [XLEN-1:0]         vj_to_issuer,
  input  logic [REG_ID_WIDTH-1:0] rs2_from_issuer,
  output logic [ROB_ID_WIDTH-1:0] qk_to_issuer,
  output logic [XLEN-1:0]         vk_to_issuer,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_ro_buffer,
  input  logic [REG_ID_WIDTH-1:0] rd_from_ro_buffer,
  input  logic [XLEN-1:0]         value_from_ro_buffer
);

  localparam int NREG = 1 << REG_ID_WIDTH;

  logic [XLEN-1:0]         value [1:NREG-1];
  logic [ROB_ID_WIDTH-1:0] tag   [1:NREG-1];

  logic                    commit;
  logic                    rename;
  logic [ROB_ID_WIDTH-1:0] tag1;
  logic [ROB_ID_WIDTH-1:0] tag2;
  logic [XLEN-1:0]         val1;
  logic [XLEN-1:0]         val2;
  logic                    hit1;
  logic                    hit2;

  assign commit = (dest_from_ro_buffer != '0) && (rd_from_ro_buffer != '0);
  assign rename = valid_from_issuer && !reset_from_rob_bus && (rd_from_issuer != '0);

  // Operand resolution: x0 reads zero, a commit bypass beats a pending tag, otherwise tag or value.
  function automatic logic [ROB_ID_WIDTH+XLEN-1:0] read_port(
    input logic [REG_ID_WIDTH-1:0] rs,
    input logic [ROB_ID_WIDTH-1:0] rs_tag,
    input logic [XLEN-1:0]         rs_value,
    input logic                    bypass_hit,
    input logic [XLEN-1:0]         bypass_value
  );
    logic [ROB_ID_WIDTH+XLEN-1:0] r;
    if (rs == '0) begin
      r = '0;
    end else if (bypass_hit) begin
      r = {{ROB_ID_WIDTH{1'b0}}, bypass_value};
    end else if (rs_tag != '0) begin
      r = {rs_tag, {XLEN{1'b0}}};
    end else begin
      r = {{ROB_ID_WIDTH{1'b0}}, rs_value};
    end
    return r;
  endfunction

  // Tag priority per register: reset, then flush, then rename, then commit-clear of the latest producer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) begin
        value[i] <= '0;
        tag[i]   <= '0;
      end
    end else if (rdy) begin
      for (int i = 1; i < NREG; i++) begin
        if (commit && (rd_from_ro_buffer == REG_ID_WIDTH'(i))) begin
          value[i] <= value_from_ro_buffer;
        end
        if (reset_from_rob_bus) begin
          tag[i] <= '0;
        end else if (rename && (rd_from_issuer == REG_ID_WIDTH'(i))) begin
          tag[i] <= dest_from_issuer;
        end else if (commit && (rd_from_ro_buffer == REG_ID_WIDTH'(i)) &&
                     (tag[i] == dest_from_ro_buffer)) begin
          tag[i] <= '0;
        end
      end
    end
  end

  // Combinational read ports observe pre-edge state, so a same-cycle rename is not visible.
  always_comb begin
    tag1 = '0;
    val1 = '0;
    tag2 = '0;
    val2 = '0;
    hit1 = 1'b0;
    hit2 = 1'b0;
    if (rs1_from_issuer != '0) begin
      tag1 = tag[rs1_from_issuer];
      val1 = value[rs1_from_issuer];
    end else begin
      tag1 = '0;
      val1 = '0;
    end
    if (rs2_from_issuer != '0) begin
      tag2 = tag[rs2_from_issuer];
      val2 = value[rs2_from_issuer];
    end else begin
      tag2 = '0;
      val2 = '0;
    end
`ifdef REG_FILE_COMMIT_BYPASS_EN
    hit1 = (dest_from_ro_buffer != '0) && (rs1_from_issuer == rd_from_ro_buffer) &&
           (tag1 == dest_from_ro_buffer);
    hit2 = (dest_from_ro_buffer != '0) && (rs2_from_issuer == rd_from_ro_buffer) &&
           (tag2 == dest_from_ro_buffer);
`endif
    {qj_to_issuer, vj_to_issuer} = read_port(rs1_from_issuer, tag1, val1, hit1, value_from_ro_buffer);
    {qk_to_issuer, vk_to_issuer} = read_port(rs2_from_issuer, tag2, val2, hit2, value_from_ro_buffer);
  end

`ifdef FORMAL
  reg_file_checker #(.ROB_ID_WIDTH(ROB_ID_WIDTH)) u_checker (
    .clk               (clk),
    .rst               (rst),
    .valid_from_issuer (valid_from_issuer),
    .dest_from_issuer  (dest_from_issuer)
  );
`endif

endmodule

`ifdef FORMAL
// A rename must always carry a real ROB id; id 0 is reserved for "ready".
module reg_file_checker #(
  parameter int ROB_ID_WIDTH = 4
) (
  input logic                    clk,
  input logic                    rst,
  input logic                    valid_from_issuer,
  input logic [ROB_ID_WIDTH-1:0] dest_from_issuer
);
  a_rename_id_nonzero: assert property (@(posedge clk) disable iff (rst)
    valid_from_issuer |-> (dest_from_issuer != '0));
endmodule
`endif

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: each task queues expected operand reads and then drains them against the read ports.
module tb_reg_file;
  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int QW   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            rdy;
  logic            flush;
  logic            valid;
  logic [RW-1:0]   rd_iss;
  logic [QW-1:0]   dest_iss;
  logic [RW-1:0]   rs1;
  logic [RW-1:0]   rs2;
  logic [QW-1:0]   qj;
  logic [QW-1:0]   qk;
  logic [XLEN-1:0] vj;
  logic [XLEN-1:0] vk;
  logic [QW-1:0]   dest_rob;
  logic [RW-1:0]   rd_rob;
  logic [XLEN-1:0] value_rob;

  typedef struct {
    string         name;
    bit            port;
    logic [RW-1:0] rs;
    logic [QW-1:0] q;
    logic [XLEN-1:0] v;
  } exp_t;

  exp_t            sb[$];
  exp_t            e;
  int              checks = 0;
  int              errors = 0;
  logic [QW-1:0]   oq;
  logic [XLEN-1:0] ov;

  reg_file #(.XLEN(XLEN), .REG_ID_WIDTH(RW), .ROB_ID_WIDTH(QW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .rdy                  (rdy),
    .reset_from_rob_bus   (flush),
    .valid_from_issuer    (valid),
    .rd_from_issuer       (rd_iss),
    .dest_from_issuer     (dest_iss),
    .rs1_from_issuer      (rs1),
    .qj_to_issuer         (qj),
    .vj_to_issuer         (vj),
    .rs2_from_issuer      (rs2),
    .qk_to_issuer         (qk),
    .vk_to_issuer         (vk),
    .dest_from_ro_buffer  (dest_rob),
    .rd_from_ro_buffer    (rd_rob),
    .value_from_ro_buffer (value_rob)
  );

  always #10 clk = ~clk;

  task automatic clear_ctl();
    valid = 1'b0; rd_iss = '0; dest_iss = '0; flush = 1'b0;
    dest_rob = '0; rd_rob = '0; value_rob = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_ctl();
  endtask

  task automatic do_rename(input logic [RW-1:0] rd, input logic [QW-1:0] id);
    valid = 1'b1; rd_iss = rd; dest_iss = id;
    step();
  endtask

  task automatic do_commit(input logic [QW-1:0] id, input logic [RW-1:0] rd, input logic [XLEN-1:0] val);
    dest_rob = id; rd_rob = rd; value_rob = val;
    step();
  endtask

  task automatic expect_rd(input string name, input bit port, input logic [RW-1:0] rs,
                           input logic [QW-1:0] q, input logic [XLEN-1:0] v);
    sb.push_back('{name, port, rs, q, v});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    valid = 1'b1; rd_iss = 5'd5; dest_iss = 4'd3;
    dest_rob = 4'd3; rd_rob = 5'd7; value_rob = 32'h77;
    step();
    rst = 1'b0;
    expect_rd("reset_x5", 1'b0, 5'd5, 4'd0, 32'h0);
    expect_rd("reset_x0", 1'b1, 5'd0, 4'd0, 32'h0);
    expect_rd("reset_x7", 1'b0, 5'd7, 4'd0, 32'h0);
    expect_rd("reset_x31", 1'b1, 5'd31, 4'd0, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port) rs2 = e.rs; else rs1 = e.rs;
      #1; oq = e.port ? qk : qj; ov = e.port ? vk : vj; checks++;
      if (oq !== e.q || ov !== e.v) begin
        errors++;
        $display("FAIL %s: got q=%0d v=0x%0h, expected q=%0d v=0x%0h", e.name, oq, ov, e.q, e.v);
      end
    end
    do_commit(4'd3, 5'd0, 32'h7);
    do_commit(4'd0, 5'd4, 32'h99);
    expect_rd("x0_commit_ignored", 1'b0, 5'd0, 4'd0, 32'h0);
    expect_rd("dest0_no_commit", 1'b1, 5'd4, 4'd0, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port) rs2 = e.rs; else rs1 = e.rs;
      #1; oq = e.port ? qk : qj; ov = e.port ? vk : vj; checks++;
      if (oq !== e.q || ov !== e.v) begin
        errors++;
        $display("FAIL %s: got q=%0d v=0x%0h, expected q=%0d v=0x%0h", e.name, oq, ov, e.q, e.v);
      end
    end
  endtask

  task automatic test_rename_commit();
    do_rename(5'd5, 4'd3);
    do_rename(5'd0, 4'd6);
    expect_rd("rename_x5_tag", 1'b0, 5'd5, 4'd3, 32'h0);
    expect_rd("rename_x0_ignored", 1'b1, 5'd0, 4'd0, 32'h0);
    valid = 1'b1; rd_iss = 5'd9; dest_iss = 4'd4;
    expect_rd("same_cycle_rename_hidden", 1'b1, 5'd9, 4'd0, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port) rs2 = e.rs; else rs1 = e.rs;
      #1; oq = e.port ? qk : qj; ov = e.port ? vk : vj; checks++;
      if (oq !== e.q || ov !== e.v) begin
        errors++;
        $display("FAIL %s: got q=%0d v=0x%0h, expected q=%0d v=0x%0h", e.name, oq, ov, e.q, e.v);
      end
    end
    step();
    do_commit(4'd3, 5'd5, 32'h1234);
    expect_rd("commit_x5_value", 1'b0, 5'd5, 4'd0, 32'h1234);
    expect_rd("rename_x9_tag", 1'b1, 5'd9, 4'd4, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port) rs2 = e.rs; else rs1 = e.rs;
      #1; oq = e.port ? qk : qj; ov = e.port ? vk : vj; checks++;
      if (oq !== e.q || ov !== e.v) begin
        errors++;
        $display("FAIL %s: got q=%0d v=0x%0h, expected q=%0d v=0x%0h", e.name, oq, ov, e.q, e.v);
      end
    end
  endtask

  task automatic test_stale_commit();
    do_rename(5'd5, 4'd3);
    do_rename(5'd5, 4'd7);
    expect_rd("rerename_x5", 1'b0, 5'd5, 4'd7, 32'h0);
    do_commit(4'd3, 5'd5, 32'hAA);
    expect_rd("stale_commit_keeps_tag", 1'b1, 5'd5, 4'd7, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port) rs2 = e.rs; else rs1 = e.rs;
      #1; oq = e.port ? qk : qj; ov = e.port ? vk : vj; checks++;
      if (oq !== e.q || ov !== e.v) begin
        errors++;
        $display("FAIL %s: got q=%0d v=0x%0h, expected q=%0d v=0x%0h", e.name, oq, ov, e.q, e.v);
      end
    end
    flush = 1'b1;
    step();
    expect_rd("stale_commit_wrote_value", 1'b0, 5'd5, 4'd0, 32'hAA);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port) rs2 = e.rs; else rs1 = e.rs;
      #1; oq = e.port ? qk : qj; ov = e.port ? vk : vj; checks++;
      if (oq !== e.q || ov !== e.v) begin
        errors++;
        $display("FAIL %s: got q=%0d v=0x%0h, expected q=%0d v=0x%0h", e.name, oq, ov, e.q, e.v);
      end
    end
    do_rename(5'd5, 4'd7);
    do_commit(4'd7, 5'd5, 32'hBB);
    expect_rd("latest_commit_clears", 1'b0, 5'd5, 4'd0, 32'hBB);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port) rs2 = e.rs; else rs1 = e.rs;
      #1; oq = e.port ? qk : qj; ov = e.port ? vk : vj; checks++;
      if (oq !== e.q || ov !== e.v) begin
        errors++;
        $display("FAIL %s: got q=%0d v=0x%0h, expected q=%0d v=0x%0h", e.name, oq, ov, e.q, e.v);
      end
    end
  endtask

  task automatic test_same_cycle();
    dest_rob = 4'd4; rd_rob = 5'd6; value_rob = 32'h9;
    valid = 1'b1; rd_iss = 5'd6; dest_iss = 4'd5;
    step();
    expect_rd("rename_wins_over_commit", 1'b1, 5'd6, 4'd5, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port) rs2 = e.rs; else rs1 = e.rs;
      #1; oq = e.port ? qk : qj; ov = e.port ? vk : vj; checks++;
      if (oq !== e.q || ov !== e.v) begin
        errors++;
        $display("FAIL %s: got q=%0d v=0x%0h, expected q=%0d v=0x%0h", e.name, oq, ov, e.q, e.v);
      end
    end
    flush = 1'b1;
    step();
    expect_rd("flush_keeps_value", 1'b1, 5'd6, 4'd0, 32'h9);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port) rs2 = e.rs; else rs1 = e.rs;
      #1; oq = e.port ? qk : qj; ov = e.port ? vk : vj; checks++;
      if (oq !== e.q || ov !== e.v) begin
        errors++;
        $display("FAIL %s: got q=%0d v=0x%0h, expected q=%0d v=0x%0h", e.name, oq, ov, e.q, e.v);
      end
    end
  endtask

  task automatic test_flush();
    do_rename(5'd1, 4'd2);
    do_rename(5'd2, 4'd3);
    expect_rd("pending_x1", 1'b0, 5'd1, 4'd2, 32'h0);
    expect_rd("pending_x2", 1'b1, 5'd2, 4'd3, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port) rs2 = e.rs; else rs1 = e.rs;
      #1; oq = e.port ? qk : qj; ov = e.port ? vk : vj; checks++;
      if (oq !== e.q || ov !== e.v) begin
        errors++;
        $display("FAIL %s: got q=%0d v=0x%0h, expected q=%0d v=0x%0h", e.name, oq, ov, e.q, e.v);
      end
    end
    flush = 1'b1; valid = 1'b1; rd_iss = 5'd3; dest_iss = 4'd4;
    step();
    rdy = 1'b0;
    do_rename(5'd1, 4'd6);
    do_rename(5'd4, 4'd7);
    dest_rob = 4'd5; rd_rob = 5'd2; value_rob = 32'h22;
    step();
    expect_rd("flush_x1", 1'b0, 5'd1, 4'd0, 32'h0);
    expect_rd("flush_x2", 1'b1, 5'd2, 4'd0, 32'h0);
    expect_rd("flush_drops_rename_x3", 1'b0, 5'd3, 4'd0, 32'h0);
    expect_rd("rdy_low_holds_x4", 1'b1, 5'd4, 4'd0, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port) rs2 = e.rs; else rs1 = e.rs;
      #1; oq = e.port ? qk : qj; ov = e.port ? vk : vj; checks++;
      if (oq !== e.q || ov !== e.v) begin
        errors++;
        $display("FAIL %s: got q=%0d v=0x%0h, expected q=%0d v=0x%0h", e.name, oq, ov, e.q, e.v);
      end
    end
    rdy = 1'b1;
    do_rename(5'd1, 4'd2);
    rdy = 1'b0; flush = 1'b1;
    step();
    rdy = 1'b1;
    expect_rd("rdy_low_blocks_flush", 1'b0, 5'd1, 4'd2, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port) rs2 = e.rs; else rs1 = e.rs;
      #1; oq = e.port ? qk : qj; ov = e.port ? vk : vj; checks++;
      if (oq !== e.q || ov !== e.v) begin
        errors++;
        $display("FAIL %s: got q=%0d v=0x%0h, expected q=%0d v=0x%0h", e.name, oq, ov, e.q, e.v);
      end
    end
    do_rename(5'd2, 4'd5);
    flush = 1'b1; dest_rob = 4'd5; rd_rob = 5'd2; value_rob = 32'h22;
    step();
    expect_rd("flush_x1_again", 1'b0, 5'd1, 4'd0, 32'h0);
    expect_rd("flush_with_commit_value", 1'b1, 5'd2, 4'd0, 32'h22);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port) rs2 = e.rs; else rs1 = e.rs;
      #1; oq = e.port ? qk : qj; ov = e.port ? vk : vj; checks++;
      if (oq !== e.q || ov !== e.v) begin
        errors++;
        $display("FAIL %s: got q=%0d v=0x%0h, expected q=%0d v=0x%0h", e.name, oq, ov, e.q, e.v);
      end
    end
  endtask

  task automatic test_bypass();
    do_rename(5'd8, 4'd2);
    dest_rob = 4'd2; rd_rob = 5'd8; value_rob = 32'h55;
`ifdef REG_FILE_COMMIT_BYPASS_EN
    expect_rd("bypass_rs2", 1'b1, 5'd8, 4'd0, 32'h55);
    expect_rd("bypass_rs1", 1'b0, 5'd8, 4'd0, 32'h55);
`else
    expect_rd("no_bypass_rs2", 1'b1, 5'd8, 4'd2, 32'h0);
    expect_rd("no_bypass_rs1", 1'b0, 5'd8, 4'd2, 32'h0);
`endif
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port) rs2 = e.rs; else rs1 = e.rs;
      #1; oq = e.port ? qk : qj; ov = e.port ? vk : vj; checks++;
      if (oq !== e.q || ov !== e.v) begin
        errors++;
        $display("FAIL %s: got q=%0d v=0x%0h, expected q=%0d v=0x%0h", e.name, oq, ov, e.q, e.v);
      end
    end
    step();
    expect_rd("after_bypass_commit", 1'b1, 5'd8, 4'd0, 32'h55);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port) rs2 = e.rs; else rs1 = e.rs;
      #1; oq = e.port ? qk : qj; ov = e.port ? vk : vj; checks++;
      if (oq !== e.q || ov !== e.v) begin
        errors++;
        $display("FAIL %s: got q=%0d v=0x%0h, expected q=%0d v=0x%0h", e.name, oq, ov, e.q, e.v);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Rename x(10+i) while committing the previous register every cycle.
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1; rd_iss = RW'(10 + i); dest_iss = QW'(i + 1);
      if (i > 0) begin
        dest_rob = QW'(i); rd_rob = RW'(9 + i); value_rob = 32'hC0DE_0000 + 32'(9 + i);
      end
      step();
    end
    expect_rd("b2b_pending_x17", 1'b0, 5'd17, 4'd8, 32'h0);
    expect_rd("b2b_done_x16", 1'b1, 5'd16, 4'd0, 32'hC0DE_0010);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port) rs2 = e.rs; else rs1 = e.rs;
      #1; oq = e.port ? qk : qj; ov = e.port ? vk : vj; checks++;
      if (oq !== e.q || ov !== e.v) begin
        errors++;
        $display("FAIL %s: got q=%0d v=0x%0h, expected q=%0d v=0x%0h", e.name, oq, ov, e.q, e.v);
      end
    end
    do_commit(4'd8, 5'd17, 32'hC0DE_0011);
    for (int r = 10; r < 18; r++) begin
      expect_rd($sformatf("b2b_x%0d", r), r[0], RW'(r), 4'd0, 32'hC0DE_0000 + 32'(r));
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port) rs2 = e.rs; else rs1 = e.rs;
      #1; oq = e.port ? qk : qj; ov = e.port ? vk : vj; checks++;
      if (oq !== e.q || ov !== e.v) begin
        errors++;
        $display("FAIL %s: got q=%0d v=0x%0h, expected q=%0d v=0x%0h", e.name, oq, ov, e.q, e.v);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary within the time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    rs1 = '0;
    rs2 = '0;
    clear_ctl();
    test_reset();
    test_rename_commit();
    test_stale_commit();
    test_same_cycle();
    test_flush();
    test_bypass();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
